// File: rtl/regfile_mp_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam int unsigned DATAWIDTH = 16;
  localparam int unsigned REGWIDTH  = 4;
  localparam int unsigned RF_NRD    = 2;

  // Clear sequencer state: sweeping the array, or in normal operation
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Write port, packed read ports and status of the register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NRD    = 2
);

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  busy;
  logic                  wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, wr_drop
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: zeroes one register per cycle, then hands over to normal operation.
module regfile_clear_fsm
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = REGWIDTH,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  output logic              o_busy,
  output logic              o_wr_drop,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_idx
);

  // r0 never needs clearing when it is hardwired to zero
  localparam logic [ADDR_W-1:0] StartIdx = ZERO_REG ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LastIdx  = '1;

  rf_state_e         r_state;
  logic              r_busy;
  logic              r_wr_drop;
  logic [ADDR_W-1:0] r_clr_idx;

  // State, sweep index and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= RF_CLEAR;
      r_busy    <= 1'b1;
      r_wr_drop <= 1'b0;
      r_clr_idx <= StartIdx;
    end else begin
      r_wr_drop <= (r_state == RF_CLEAR) && i_wr_en;
      case (r_state)
        RF_CLEAR: begin
          // Leaving at the last index means clr_idx never has to wrap
          if (r_clr_idx == LastIdx) begin
            r_state <= RF_READY;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + ADDR_W'(1);
          end
        end
        default: begin
          r_state <= RF_READY;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_we  = r_busy;
  assign o_wr_drop = r_wr_drop;
  assign o_clr_idx = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NRD combinational read ports, one posedge write port,
// optional hardwired-zero r0 and same-cycle write-to-read bypass.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATAWIDTH,
  parameter int unsigned ADDR_W   = REGWIDTH,
  parameter int unsigned NRD      = RF_NRD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  regfile_mp_if.slave  io_bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_usr_we;

  regfile_clear_fsm #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clear_fsm (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (io_bus.wr_en),
    .o_busy    (w_busy),
    .o_wr_drop (io_bus.wr_drop),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  // Writes to a hardwired r0 are dropped silently (no wr_drop pulse)
  assign w_usr_we = io_bus.wr_en && !w_busy && !(ZERO_REG && (io_bus.wr_addr == '0));

  // Storage: the clear sweep owns the write port while busy
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_usr_we) begin
      r_mem[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  assign io_bus.busy = w_busy;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = io_bus.rd_addr[gi*ADDR_W +: ADDR_W];

    // Per-port read mux: busy, then zero register, then bypass, then array
    always_comb begin
      w_data = r_mem[w_addr];
      if (w_busy) begin
        w_data = '0;
      end else if (ZERO_REG && (w_addr == '0)) begin
        w_data = '0;
      end else if (BYPASS && io_bus.wr_en && (io_bus.wr_addr == w_addr)) begin
        w_data = io_bus.wr_data;
      end
    end

    assign io_bus.rd_data[gi*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: default regfile (16x16, 2 ports, r0 zero, bypass)
// plus an 8-entry, 4-port instance with ordinary r0 and no bypass.
module tb_regfile_mp;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_vec;
  int n_err;
  int na;
  int nb;
  int bad;

  regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NRD(2)) ifa ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NRD(4)) ifb ();

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .NRD      (2),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) u_dut_a (
    .i_clk   (clk),
    .i_reset (rst_a),
    .io_bus  (ifa)
  );

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .NRD      (4),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0)
  ) u_dut_b (
    .i_clk   (clk),
    .i_reset (rst_b),
    .io_bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = {4'd5, 4'd9};
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = {4{3'd7}};
    tick();

    // Reset state
    chk("rst_busy_a", 64'(ifa.busy), 64'd1);
    chk("rst_drop_a", 64'(ifa.wr_drop), 64'd0);
    chk("rst_busy_b", 64'(ifb.busy), 64'd1);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // T1: sweep lengths and zero reads throughout
    na  = ifa.busy ? 1 : 0;
    nb  = ifb.busy ? 1 : 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.rd_data !== '0 || ifb.rd_data !== '0) bad++;
      tick();
      if (ifa.busy) na++;
      if (ifb.busy) nb++;
    end
    if (ifa.rd_data !== '0 || ifb.rd_data !== '0) bad++;
    chk("t1_busy_len_a", 64'(na), 64'd15);
    chk("t1_busy_len_b", 64'(nb), 64'd8);
    chk("t1_rd_zero", 64'(bad), 64'd0);

    // T2: bypass in the write cycle, stored value the next cycle
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd5; ifa.wr_data = 16'hBEEF; ifa.rd_addr = {4'd5, 4'd9};
    #1;
    chk("t2_bypass", 64'(ifa.rd_data), 64'hBEEF_0000);
    tick();
    ifa.wr_en = 1'b0; ifa.rd_addr = {4'd9, 4'd5};
    #1;
    chk("t2_stored", 64'(ifa.rd_data), 64'h0000_BEEF);

    // T3: r0 is hardwired zero; its write is silent
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd0; ifa.wr_data = 16'hFFFF; ifa.rd_addr = '0;
    #1;
    chk("t3_r0_wcycle", 64'(ifa.rd_data), 64'd0);
    tick();
    ifa.wr_en = 1'b0;
    #1;
    chk("t3_r0_after", 64'(ifa.rd_data), 64'd0);
    chk("t3_no_drop", 64'(ifa.wr_drop), 64'd0);

    // T4: write during sweep is dropped and flagged
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd3; ifa.wr_data = 16'h1234; ifa.rd_addr = {4'd3, 4'd5};
    #1;
    chk("t4_busy_rd", 64'(ifa.rd_data), 64'd0);
    tick();
    ifa.wr_en = 1'b0;
    chk("t4_drop_set", 64'(ifa.wr_drop), 64'd1);
    tick();
    chk("t4_drop_clr", 64'(ifa.wr_drop), 64'd0);
    repeat (20) tick();
    chk("t4_idle", 64'(ifa.busy), 64'd0);
    chk("t4_r3_r5_zero", 64'(ifa.rd_data), 64'd0);

    // T5: reset mid-sweep restarts the full sweep
    ifa.wr_en = 1'b1; ifa.wr_addr = 4'd7; ifa.wr_data = 16'hA5A5;
    tick();
    ifa.wr_en = 1'b0; ifa.rd_addr = {4'd0, 4'd7};
    #1;
    chk("t5_r7_written", 64'(ifa.rd_data), 64'h0000_A5A5);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    repeat (7) tick();
    chk("t5_busy_c8", 64'(ifa.busy), 64'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    na = ifa.busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.busy) na++;
    end
    chk("t5_busy_len", 64'(na), 64'd15);
    chk("t5_r7_zero", 64'(ifa.rd_data), 64'd0);

    // T6: no bypass, four ports on one address, ordinary r0
    ifb.wr_en = 1'b1; ifb.wr_addr = 3'd2; ifb.wr_data = 16'h0F0F; ifb.rd_addr = {4{3'd2}};
    #1;
    chk("t6_old_value", 64'(ifb.rd_data), 64'd0);
    tick();
    ifb.wr_en = 1'b0;
    #1;
    chk("t6_new_value", 64'(ifb.rd_data), {4{16'h0F0F}});
    ifb.wr_en = 1'b1; ifb.wr_addr = 3'd0; ifb.wr_data = 16'h1111;
    tick();
    ifb.wr_en = 1'b0; ifb.rd_addr = {3'd2, 3'd0, 3'd2, 3'd0};
    #1;
    chk("t6_r0_plain", 64'(ifb.rd_data), 64'h0F0F_1111_0F0F_1111);
    chk("t6_no_drop", 64'(ifb.wr_drop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
